// File: rtl/tone_pkg.sv
// Shared constants for the tone bank: semitone indices, top-octave dividers
// at 50 MHz and the level-to-amplitude mapping.
package tone_pkg;

    localparam int unsigned NUM_SEMI = 12;

    localparam int unsigned SEMI_C  = 0,  SEMI_CS = 1,  SEMI_D  = 2,  SEMI_DS = 3,
                            SEMI_E  = 4,  SEMI_F  = 5,  SEMI_FS = 6,  SEMI_G  = 7,
                            SEMI_GS = 8,  SEMI_A  = 9,  SEMI_AS = 10, SEMI_B  = 11;

    // Top-octave half-period dividers (clocks - 1), C through B.
    localparam int unsigned TOP_DIV [NUM_SEMI] = '{
        47778, 45097, 42566, 40177, 37922, 35794,
        33785, 31888, 30099, 28409, 26815, 25310
    };

    // Full-scale is a quarter of the sample range so the mix has headroom.
    function automatic logic [31:0] amp_from_level(input int unsigned amp_w,
                                                   input logic [1:0]  level);
        logic [31:0] full;
        full = (32'd1 << (amp_w - 32'd2)) - 32'd1;
        return full >> (2'd3 - level);
    endfunction

endpackage

// File: rtl/tone_divider.sv
// One semitone oscillator: top-octave divider plus a binary octave counter
// whose bits give phase-locked square waves for every octave.
module tone_divider #(
    parameter int unsigned CNT_W   = 20,
    parameter int unsigned NUM_OCT = 3,
    parameter int unsigned DIV     = 1000
) (
    input  logic               clk,
    input  logic               rst,
    output logic [NUM_OCT-1:0] o_phase
);

    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_OCT-1:0] r_oct;
    logic               w_tick;

    assign w_tick = (r_cnt == CNT_W'(DIV));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_oct <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
            if (w_tick) begin
                r_oct <= r_oct + NUM_OCT'(1);
            end
        end
    end

    // Octave 0 (lowest) is the MSB of the octave counter.
    for (genvar o = 0; o < NUM_OCT; o++) begin : g_phase
        assign o_phase[o] = r_oct[NUM_OCT-1-o];
    end

endmodule

// File: rtl/tone_bank.sv
// Twelve-semitone, multi-octave square-wave bank with key gating,
// selectable amplitude and a saturating registered mix.
module tone_bank
    import tone_pkg::*;
#(
    parameter int unsigned NUM_OCT   = 3,
    parameter int unsigned AMP_W     = 16,
    parameter int unsigned CNT_W     = 20,
    parameter int unsigned DIV_SHIFT = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [12*NUM_OCT-1:0]        keys,
    input  logic [1:0]                   level,
    output logic [12*NUM_OCT*AMP_W-1:0]  notes,
    output logic [AMP_W-1:0]             mix,
    output logic                         mix_valid
);

    localparam int unsigned NUM_NOTE = NUM_SEMI * NUM_OCT;
    localparam int unsigned SUM_W    = AMP_W + $clog2(NUM_NOTE);

    logic [NUM_OCT-1:0]        w_phase [NUM_SEMI];
    logic [NUM_NOTE-1:0]       w_gate;
    logic [AMP_W-1:0]          w_amp;
    logic [SUM_W-1:0]          w_sum;
    logic [AMP_W-1:0]          w_mix_sat;
    logic [NUM_NOTE*AMP_W-1:0] r_notes;
    logic [AMP_W-1:0]          r_mix;
    logic                      r_vld_pre;
    logic                      r_mix_valid;

    for (genvar s = 0; s < NUM_SEMI; s++) begin : g_semi
        tone_divider #(
            .CNT_W   (CNT_W),
            .NUM_OCT (NUM_OCT),
            .DIV     (TOP_DIV[s] >> DIV_SHIFT)
        ) u_div (
            .clk     (clk),
            .rst     (rst),
            .o_phase (w_phase[s])
        );
    end

    // Note n = oct*12 + semitone.
    for (genvar n = 0; n < NUM_NOTE; n++) begin : g_gate
        assign w_gate[n] = keys[n] & w_phase[n % NUM_SEMI][n / NUM_SEMI];
    end

    assign w_amp = AMP_W'(amp_from_level(AMP_W, level));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_notes <= '0;
        end else begin
            for (int n = 0; n < int'(NUM_NOTE); n++) begin
                r_notes[n*AMP_W +: AMP_W] <= w_gate[n] ? w_amp : '0;
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int n = 0; n < int'(NUM_NOTE); n++) begin
            w_sum = w_sum + SUM_W'(r_notes[n*AMP_W +: AMP_W]);
        end
    end

    assign w_mix_sat = (w_sum > SUM_W'({AMP_W{1'b1}})) ? {AMP_W{1'b1}} : w_sum[AMP_W-1:0];

    // mix_valid rises on the second edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mix       <= '0;
            r_vld_pre   <= 1'b0;
            r_mix_valid <= 1'b0;
        end else begin
            r_mix       <= w_mix_sat;
            r_vld_pre   <= 1'b1;
            r_mix_valid <= r_vld_pre;
        end
    end

    assign notes     = r_notes;
    assign mix       = r_mix;
    assign mix_valid = r_mix_valid;

endmodule

// File: tb/tb_tone_bank.sv
// Scoreboard bench for tone_bank (NUM_OCT=3, DIV_SHIFT=10): stimulus queues
// cycle-stamped expectations, a negedge monitor pops and compares them.
module tb_tone_bank;

    localparam int unsigned AMP_W = 16;
    localparam int unsigned NN    = 36;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NN-1:0]     keys;
    logic [1:0]        level;
    logic [NN*AMP_W-1:0] notes;
    logic [AMP_W-1:0]  mix;
    logic              mix_valid;

    tone_bank #(
        .NUM_OCT   (3),
        .AMP_W     (16),
        .CNT_W     (20),
        .DIV_SHIFT (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keys      (keys),
        .level     (level),
        .notes     (notes),
        .mix       (mix),
        .mix_valid (mix_valid)
    );

    always #5 clk = ~clk;

    typedef enum int {K_NOTE, K_MIX, K_VALID, K_TOG} kind_e;
    typedef struct {
        int    cyc;
        kind_e kind;
        int    idx;
        int    exp;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   rel   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    // Hand-derived TOP_DIV >> 10, C..B.
    int d_tab [12] = '{46, 44, 41, 39, 37, 34, 32, 31, 29, 27, 26, 24};

    // Toggle counters for D3, D2, D1 over a window of cycles.
    int          tog_idx  [3] = '{26, 14, 2};
    int          tog      [3] = '{0, 0, 0};
    logic [15:0] tog_prev [3];
    int          tog_lo = -1;
    int          tog_hi = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_abs(int c, kind_e k, int idx, int e, string name);
        exp_t x;
        x.cyc = c; x.kind = k; x.idx = idx; x.exp = e; x.name = name;
        sb.push_back(x);
    endfunction

    function automatic void expect_rel(int e_cyc, kind_e k, int idx, int e, string name);
        expect_abs(rel + e_cyc, k, idx, e, name);
    endfunction

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        int act;
        for (int j = 0; j < 3; j++) begin
            if (cyc > tog_lo && cyc <= tog_hi && notes[tog_idx[j]*AMP_W +: AMP_W] != tog_prev[j])
                tog[j]++;
            tog_prev[j] = notes[tog_idx[j]*AMP_W +: AMP_W];
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].kind)
                    K_NOTE:  act = int'(notes[sb[i].idx*AMP_W +: AMP_W]);
                    K_MIX:   act = int'(mix);
                    K_VALID: act = int'(mix_valid);
                    default: act = tog[sb[i].idx];
                endcase
                n_vec++;
                if (sb[i].cyc < cyc) begin
                    n_err++;
                    $display("FAIL %s: expected at cycle %0d, not sampled (now %0d), want 0x%0h",
                             sb[i].name, sb[i].cyc, cyc, sb[i].exp);
                end else if (act != sb[i].exp) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h",
                             sb[i].name, cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rel(int e);
        while (cyc - rel < e) step(1);
    endtask

    task automatic do_reset(logic [NN-1:0] k, logic [1:0] lv);
        step(1);
        rst   = 1'b0;
        keys  = k;
        level = lv;
        step(2);
        rst = 1'b1;
        rel = cyc;
    endtask

    initial begin
        exp_t x;
        keys  = '1;
        level = 2'd3;
        #2 rst = 1'b0;
        step(2);
        expect_abs(cyc, K_MIX,   0,  0, "por_mix");
        expect_abs(cyc, K_VALID, 0,  0, "por_valid");
        expect_abs(cyc, K_NOTE,  33, 0, "por_note_A3");
        step(1);
        rst = 1'b1;
        rel = cyc;

        // Run A: all keys, level 3 -- octave periods and mix saturation.
        expect_rel(1,   K_VALID, 0,  0,       "valid_e1");
        expect_rel(2,   K_VALID, 0,  1,       "valid_e2");
        expect_rel(2,   K_MIX,   0,  0,       "mix_e2");
        expect_rel(28,  K_NOTE,  33, 0,       "A3_e28");
        expect_rel(29,  K_NOTE,  33, 'h3FFF,  "A3_e29");
        expect_rel(56,  K_NOTE,  33, 'h3FFF,  "A3_e56");
        expect_rel(57,  K_NOTE,  33, 0,       "A3_e57");
        expect_rel(85,  K_NOTE,  33, 'h3FFF,  "A3_e85");
        expect_rel(56,  K_NOTE,  21, 0,       "A2_e56");
        expect_rel(57,  K_NOTE,  21, 'h3FFF,  "A2_e57");
        expect_rel(112, K_NOTE,  21, 'h3FFF,  "A2_e112");
        expect_rel(113, K_NOTE,  21, 0,       "A2_e113");
        expect_rel(112, K_NOTE,  9,  0,       "A1_e112");
        expect_rel(113, K_NOTE,  9,  'h3FFF,  "A1_e113");
        expect_rel(224, K_NOTE,  9,  'h3FFF,  "A1_e224");
        expect_rel(225, K_NOTE,  9,  0,       "A1_e225");
        expect_rel(27,  K_MIX,   0,  'h3FFF,  "mix_one_note");
        expect_rel(29,  K_MIX,   0,  'h7FFE,  "mix_two_notes");
        expect_rel(51,  K_MIX,   0,  'hFFFF,  "mix_saturate");
        wait_rel(230);

        // Async reset between edges: everything reads zero before the next edge.
        #1 rst = 1'b0;
        for (int n = 0; n < int'(NN); n++)
            expect_abs(cyc, K_NOTE, n, 0, $sformatf("async_rst_note%0d", n));
        expect_abs(cyc, K_MIX,   0, 0, "async_rst_mix");
        expect_abs(cyc, K_VALID, 0, 0, "async_rst_valid");
        step(1);
        rst = 1'b1;
        rel = cyc;

        // Run B: first tick per semitone and octave lock on D.
        for (int s = 0; s < 12; s++) begin
            expect_rel(d_tab[s] + 1, K_NOTE, 24 + s, 0,      $sformatf("pre_tick_s%0d", s));
            expect_rel(d_tab[s] + 2, K_NOTE, 24 + s, 'h3FFF, $sformatf("first_tick_s%0d", s));
        end
        tog_lo = rel;
        tog_hi = rel + 337;
        expect_rel(336, K_NOTE, 26, 'h3FFF, "D3_pre_wrap");
        expect_rel(336, K_NOTE, 14, 'h3FFF, "D2_pre_wrap");
        expect_rel(336, K_NOTE, 2,  'h3FFF, "D1_pre_wrap");
        expect_rel(337, K_NOTE, 26, 0,      "D3_wrap");
        expect_rel(337, K_NOTE, 14, 0,      "D2_wrap");
        expect_rel(337, K_NOTE, 2,  0,      "D1_wrap");
        expect_rel(338, K_TOG,  0,  8,      "D3_toggles");
        expect_rel(338, K_TOG,  1,  4,      "D2_toggles");
        expect_rel(338, K_TOG,  2,  2,      "D1_toggles");
        wait_rel(340);

        // Run C: key gating with only C2 pressed, then released.
        do_reset(36'h1 << 12, 2'd3);
        expect_rel(94,  K_NOTE, 12, 0,      "C2_e94");
        expect_rel(95,  K_NOTE, 12, 'h3FFF, "C2_e95");
        expect_rel(95,  K_MIX,  0,  0,      "gate_mix_e95");
        expect_rel(96,  K_MIX,  0,  'h3FFF, "gate_mix_e96");
        expect_rel(50,  K_NOTE, 24, 0,      "C3_gated_off");
        expect_rel(95,  K_NOTE, 0,  0,      "C1_gated_off");
        expect_rel(100, K_NOTE, 12, 'h3FFF, "C2_held");
        expect_rel(101, K_NOTE, 12, 0,      "C2_released");
        expect_rel(101, K_MIX,  0,  'h3FFF, "mix_release_lag");
        expect_rel(102, K_MIX,  0,  0,      "mix_released");
        wait_rel(100);
        keys = '0;
        wait_rel(105);

        // Run D: level sweep on C3 during its high phase.
        do_reset(36'h1 << 24, 2'd3);
        expect_rel(50, K_NOTE, 24, 'h3FFF, "lvl3");
        expect_rel(51, K_NOTE, 24, 'h1FFF, "lvl2");
        expect_rel(52, K_NOTE, 24, 'h0FFF, "lvl1");
        expect_rel(53, K_NOTE, 24, 'h07FF, "lvl0");
        expect_rel(52, K_MIX,  0,  'h1FFF, "lvl_mix2");
        expect_rel(54, K_MIX,  0,  'h07FF, "lvl_mix0");
        wait_rel(50);
        level = 2'd2;
        wait_rel(51);
        level = 2'd1;
        wait_rel(52);
        level = 2'd0;
        wait_rel(56);

        for (int k = 0; k < 200 && sb.size() != 0; k++) step(1);
        while (sb.size() != 0) begin
            x = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: never sampled, want 0x%0h", x.name, x.exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
